// File: rtl/icache_refill_ctrl_if.sv
// Instruction-memory read port between the refill controller (master) and memory (slave).
interface icache_refill_ctrl_if #(
  parameter int dataW = 32
);
  logic             MemReq;
  logic [dataW-1:0] MemAddr;
  logic             MemAck;
  logic [31:0]      MemData;

  // A word moves on any cycle with MemReq && MemAck. While MemReq is high
  // and MemAck low, MemReq and MemAddr stay unchanged. MemAck with MemReq low
  // carries no meaning.
  modport master (output MemReq, output MemAddr, input MemAck, input MemData);
  modport slave  (input MemReq, input MemAddr, output MemAck, output MemData);
endinterface

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with word-by-word line refill over a req/ack port.
// Define ICACHE_STATS_EN to add saturating HitCount/MissCount outputs.
module icache_refill_ctrl #(
  parameter int dataW = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [dataW-1:0]     ProgAddr,
  input  logic                 Flush,
  output logic                 InsCacheStall,
  output logic [31:0]          Instr,
  icache_refill_ctrl_if.master memBus,
  output logic [1:0]           fsmState
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          HitCount,
  output logic [31:0]          MissCount
`endif
);
  localparam int WORD_BITS = $clog2(WORDS);
  localparam int IDX_BITS  = $clog2(LINES);
  localparam int IDX_LSB   = 2 + WORD_BITS;
  localparam int TAG_LSB   = IDX_LSB + IDX_BITS;
  localparam int TAG_W     = dataW - TAG_LSB;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS - 1);
  localparam logic [dataW-1:0]     LINE_MASK = dataW'(WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;
  state_t state, nextState;

  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tagMem  [LINES];
  logic [31:0]          dataMem [LINES][WORDS];
  logic [dataW-1:0]     base;
  logic [WORD_BITS-1:0] counter;

  logic [WORD_BITS-1:0] reqWord;
  logic [IDX_BITS-1:0]  reqIdx;
  logic [TAG_W-1:0]     reqTag;
  logic [IDX_BITS-1:0]  fillIdx;
  logic [TAG_W-1:0]     fillTag;
  logic                 hit;
  logic                 missStart;
  logic                 ackWord;
  logic                 fillLast;
  logic [1:0]           unusedByteBits;

  assign reqWord        = ProgAddr[IDX_LSB-1:2];
  assign reqIdx         = ProgAddr[TAG_LSB-1:IDX_LSB];
  assign reqTag         = ProgAddr[dataW-1:TAG_LSB];
  assign fillIdx        = base[TAG_LSB-1:IDX_LSB];
  assign fillTag        = base[dataW-1:TAG_LSB];
  assign unusedByteBits = ProgAddr[1:0];

  assign hit       = valid[reqIdx] && (tagMem[reqIdx] == reqTag);
  assign Instr     = dataMem[reqIdx][reqWord];
  assign missStart = (state == IDLE) && !hit;
  // A Flush in the same cycle as an ack discards that word and the line.
  assign ackWord   = (state == FILL) && memBus.MemAck && !Flush;
  assign fillLast  = ackWord && (counter == LAST_WORD);
  assign fsmState  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!hit) nextState = FILL;
      FILL:    if (Flush) nextState = IDLE;
               else if (fillLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    InsCacheStall  = 1'b1;
    memBus.MemReq  = 1'b0;
    memBus.MemAddr = '0;
    case (state)
      IDLE: InsCacheStall = !hit;
      FILL: begin
        memBus.MemReq  = 1'b1;
        memBus.MemAddr = base + dataW'({counter, 2'b00});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base    <= '0;
      counter <= '0;
    end else if (missStart) begin
      base    <= ProgAddr & ~LINE_MASK;
      counter <= '0;
    end else if (ackWord) begin
      counter <= counter + WORD_BITS'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         valid <= '0;
    else if (Flush)    valid <= '0;
    else if (fillLast) valid[fillIdx] <= 1'b1;
  end

  // Tags and data are never cleared; the valid bits alone gate a hit.
  always_ff @(posedge clock) begin
    if (ackWord)  dataMem[fillIdx][counter] <= memBus.MemData;
    if (fillLast) tagMem[fillIdx] <= fillTag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if ((state == IDLE) && hit && (HitCount != '1))  HitCount  <= HitCount + 32'd1;
      if (missStart && (MissCount != '1))              MissCount <= MissCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: vector table of fetches plus flush/reset/wait-state sequences.
module tb_icache_refill_ctrl;
  logic        clock;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic        InsCacheStall;
  logic [31:0] Instr;
  logic [1:0]  fsmState;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  icache_refill_ctrl_if #(.dataW(32)) memBus ();

  icache_refill_ctrl #(.dataW(32), .LINES(8), .WORDS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .ProgAddr      (ProgAddr),
    .Flush         (Flush),
    .InsCacheStall (InsCacheStall),
    .Instr         (Instr),
    .memBus        (memBus.master),
    .fsmState      (fsmState)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount      (HitCount),
    .MissCount     (MissCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int holdErrs = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          delay;
    int          expStall;
    logic [31:0] expInstr;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: line 0x10 holds 0xA0..0xA3, other lines shifted up by 0x100 per 16 bytes.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] hi;
    hi = (a >> 4) - 32'd1;
    return (hi << 8) | (32'hA0 + {30'd0, a[3:2]});
  endfunction

  task automatic pushLine(input logic [31:0] addr);
    for (int k = 0; k < 4; k++) exp_q.push_back((addr & ~32'hF) + 32'(4 * k));
  endtask

  task automatic scoreAddr(input logic [31:0] a);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_fetch: got %h expected none", a);
    end else begin
      e = exp_q.pop_front();
      check("fetch_addr", a, e);
    end
  endtask

  // Called just after a negedge; returns just after the negedge where the stall is low.
  task automatic doAccess(input logic [31:0] addr, input int delay, output int stall);
    int          waitCnt;
    bit          prevWait;
    logic [31:0] prevAddr;
    stall    = 0;
    waitCnt  = 0;
    prevWait = 1'b0;
    prevAddr = '0;
    ProgAddr = addr;
    #1;
    while (InsCacheStall === 1'b1 && stall < 200) begin
      stall++;
      if (prevWait && (memBus.MemReq !== 1'b1 || memBus.MemAddr !== prevAddr)) holdErrs++;
      prevWait = 1'b0;
      if (memBus.MemReq === 1'b1) begin
        if (waitCnt == delay) begin
          memBus.MemAck  = 1'b1;
          memBus.MemData = memWord(memBus.MemAddr);
          scoreAddr(memBus.MemAddr);
          waitCnt = 0;
        end else begin
          waitCnt++;
          prevWait = 1'b1;
          prevAddr = memBus.MemAddr;
        end
      end
      @(negedge clock);
      memBus.MemAck = 1'b0;
      #1;
    end
    if (stall >= 200) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got %0d cycles expected release", stall);
    end
  endtask

  initial begin
    int stall;

    vecs[0] = '{32'h10, 0, 6,  32'h0A0};
    vecs[1] = '{32'h1C, 0, 0,  32'h0A3};
    vecs[2] = '{32'h14, 0, 0,  32'h0A1};
    vecs[3] = '{32'h90, 0, 6,  32'h8A0};
    vecs[4] = '{32'h10, 0, 6,  32'h0A0};
    vecs[5] = '{32'h2C, 3, 18, 32'h1A3};
    vecs[6] = '{32'h28, 0, 0,  32'h1A2};
    vecs[7] = '{32'h94, 0, 6,  32'h8A1};
    vecs[8] = '{32'h98, 0, 0,  32'h8A2};
    vecs[9] = '{32'h24, 0, 0,  32'h1A1};

    reset          = 1'b1;
    ProgAddr       = 32'h10;
    Flush          = 1'b0;
    memBus.MemAck  = 1'b0;
    memBus.MemData = '0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_stall", InsCacheStall, 1);
    check("rst_memreq", memBus.MemReq, 0);
    check("rst_memaddr", memBus.MemAddr, 0);
    check("rst_state", fsmState, 0);
`ifdef ICACHE_STATS_EN
    check("rst_hitcount", HitCount, 0);
    check("rst_misscount", MissCount, 0);
`endif

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clock);
      if (vecs[i].expStall != 0) pushLine(vecs[i].addr);
      doAccess(vecs[i].addr, vecs[i].delay, stall);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].expStall);
      check($sformatf("vec%0d_instr", i), Instr, vecs[i].expInstr);
      check($sformatf("vec%0d_drain", i), exp_q.size(), 0);
      check($sformatf("vec%0d_memreq", i), memBus.MemReq, 0);
      exp_q.delete();
    end
    check("wait_hold_stable", holdErrs, 0);

    // Flush after two accepted words, with an ack in the flush cycle.
    @(negedge clock);
    ProgAddr = 32'h10;
    #1;
    check("fl_miss_stall", InsCacheStall, 1);
    @(negedge clock);
    #1;
    check("fl_addr0", memBus.MemAddr, 32'h10);
    memBus.MemAck  = 1'b1;
    memBus.MemData = 32'hA0;
    @(negedge clock);
    memBus.MemAck = 1'b0;
    #1;
    check("fl_addr1", memBus.MemAddr, 32'h14);
    memBus.MemAck  = 1'b1;
    memBus.MemData = 32'hA1;
    @(negedge clock);
    memBus.MemAck = 1'b0;
    #1;
    check("fl_addr2", memBus.MemAddr, 32'h18);
    Flush          = 1'b1;
    memBus.MemAck  = 1'b1;
    memBus.MemData = 32'hDEADBEEF;
    @(negedge clock);
    Flush         = 1'b0;
    memBus.MemAck = 1'b0;
    #1;
    check("fl_memreq_low", memBus.MemReq, 0);
    check("fl_state_idle", fsmState, 0);
    check("fl_still_miss", InsCacheStall, 1);
    pushLine(32'h10);
    doAccess(32'h10, 0, stall);
    check("fl_refill_stall", stall, 6);
    check("fl_refill_instr", Instr, 32'hA0);
    check("fl_refill_drain", exp_q.size(), 0);
    exp_q.delete();

    // Line 0x20 was valid before the flush; it must refill.
    @(negedge clock);
    pushLine(32'h28);
    doAccess(32'h28, 0, stall);
    check("fl_cleared_stall", stall, 6);
    check("fl_cleared_instr", Instr, 32'h1A2);
    exp_q.delete();

    // Flush while idle on a hit: hit holds this cycle, misses the next.
    @(negedge clock);
    Flush = 1'b1;
    #1;
    check("idle_flush_hit", InsCacheStall, 0);
    @(negedge clock);
    Flush = 1'b0;
    #1;
    check("idle_flush_miss", InsCacheStall, 1);
    pushLine(32'h28);
    doAccess(32'h28, 0, stall);
    check("idle_flush_refill", stall, 6);
    check("idle_flush_instr", Instr, 32'h1A2);
    exp_q.delete();

    // Stray ack while no request is outstanding.
    @(negedge clock);
    memBus.MemAck  = 1'b1;
    memBus.MemData = 32'hFFFFFFFF;
    #1;
    check("stray_memreq", memBus.MemReq, 0);
    @(negedge clock);
    memBus.MemAck = 1'b0;
    #1;
    check("stray_stall", InsCacheStall, 0);
    check("stray_instr", Instr, 32'h1A2);
    check("stray_state", fsmState, 0);

    // Reset in the middle of a fill.
    @(negedge clock);
    ProgAddr = 32'h50;
    #1;
    check("rf_miss", InsCacheStall, 1);
    @(negedge clock);
    #1;
    check("rf_req", memBus.MemReq, 1);
    memBus.MemAck  = 1'b1;
    memBus.MemData = 32'h55;
    @(negedge clock);
    memBus.MemAck = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rf_memreq", memBus.MemReq, 0);
    check("rf_state", fsmState, 0);
    check("rf_memaddr", memBus.MemAddr, 0);
    ProgAddr = 32'h28;
    #1;
    check("rf_valid_cleared", InsCacheStall, 1);
`ifdef ICACHE_STATS_EN
    check("rf_hitcount", HitCount, 0);
    check("rf_misscount", MissCount, 0);
`endif

    // One cold miss followed by five hit cycles.
    @(negedge clock);
    reset = 1'b0;
    pushLine(32'h10);
    doAccess(32'h10, 0, stall);
    check("st_stall", stall, 6);
    check("st_instr", Instr, 32'hA0);
    exp_q.delete();
    repeat (5) @(posedge clock);
    #1;
    check("st_hit_stall", InsCacheStall, 0);
`ifdef ICACHE_STATS_EN
    check("st_hitcount", HitCount, 5);
    check("st_misscount", MissCount, 1);
    reset = 1'b1;
    #1;
    check("st_rst_hitcount", HitCount, 0);
    check("st_rst_misscount", MissCount, 0);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
